// File: rtl/rr_arb_4_pkg.sv
// Shared constants for the four-requester round-robin arbiter.
// State encodings are fixed so external debug tooling can decode them.
package rr_arb_4_pkg;
    localparam int ARB_NREQ         = 4;
    localparam int ARB_MAX_HOLD_DEF = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;
endpackage

// File: rtl/rr_arb_4_if.sv
// Request/grant bundle between four clients (master) and the arbiter (slave).
// Level requests plus a done pulse in; one-hot grant, owner index, busy and timeout out.
interface rr_arb_4_if;
    import rr_arb_4_pkg::*;

    logic [ARB_NREQ-1:0] req;
    logic                done;
    logic [ARB_NREQ-1:0] gnt;
    logic [1:0]          gnt_idx;
    logic                busy;
    logic                timeout;

    modport master (
        output req, done,
        input  gnt, gnt_idx, busy, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_idx, busy, timeout
    );
endinterface

// File: rtl/rr_pick_4.sv
// Round-robin winner select: rotate so last+1 sits at bit 0, then pick the lowest set bit.
// Purely combinational; valid is low when nothing requests.
module rr_pick_4
    import rr_arb_4_pkg::*;
(
    input  logic [ARB_NREQ-1:0] req,
    input  logic [1:0]          last,
    output logic                valid,
    output logic [1:0]          win
);
    logic [1:0]          base;
    logic [1:0]          off;
    logic [ARB_NREQ-1:0] rot;

    assign base = last + 2'd1;

    always_comb begin
        rot = '0;
        off = '0;
        for (int i = 0; i < ARB_NREQ; i++) begin
            rot[i] = req[base + 2'(i)];
        end
        // Scan downward so the lowest set bit (closest to last+1) is the final assignment.
        for (int i = ARB_NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = 2'(i);
        end
    end

    assign valid = |req;
    assign win   = base + off;
endmodule

// File: rtl/rr_arb_4.sv
// Four-way round-robin arbiter, IDLE -> GRANT -> TURN; req to gnt is one cycle, owners
// separated by two dead cycles. Optional forced release after MAX_HOLD cycles under ARB_TIMEOUT_EN.
module rr_arb_4
    import rr_arb_4_pkg::*;
#(
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
    parameter int CNT_W    = 5
)(
    input  logic       clk,
    input  logic       rst,
    rr_arb_4_if.slave  arb
);
    logic [1:0] state;
    logic [1:0] last;
    logic       pick_vld;
    logic [1:0] pick_win;
    logic       release_c;
    logic       force_rel;

    if (MAX_HOLD < 1 || MAX_HOLD > (2**CNT_W) - 1) begin : g_bad_max_hold
        $error("rr_arb_4: MAX_HOLD out of range for CNT_W");
    end

    rr_pick_4 u_pick (
        .req   (arb.req),
        .last  (last),
        .valid (pick_vld),
        .win   (pick_win)
    );

    // Done and owner dropping its request in the same cycle are one release.
    assign release_c = arb.done || !arb.req[last];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            last  <= 2'd3;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state <= ST_GRANT;
                        last  <= pick_win;
                    end
                end
                ST_GRANT: begin
                    if (release_c || force_rel) state <= ST_TURN;
                end
                ST_TURN:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;
    logic             timeout_q;

    assign force_rel = (state == ST_GRANT) && !release_c &&
                       (hold_cnt == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= force_rel;
            if (state != ST_GRANT)
                hold_cnt <= '0;
            else if (hold_cnt != '1)
                hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign arb.timeout = timeout_q;
`else
    assign force_rel   = 1'b0;
    assign arb.timeout = 1'b0;
`endif

    assign arb.busy    = (state == ST_GRANT);
    assign arb.gnt_idx = last;
    assign arb.gnt     = arb.busy ? (4'b0001 << last) : 4'b0000;
endmodule

// File: tb/tb_rr_arb_4.sv
// Directed bench for rr_arb_4 with MAX_HOLD=4; timeout scenarios follow ARB_TIMEOUT_EN.
module tb_rr_arb_4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    rr_arb_4_if arb_if ();

    rr_arb_4 #(.MAX_HOLD(4), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arb_if.req  = 4'b0000;
        arb_if.done = 1'b0;
        rst = 1'b1;
        tick();
        total++;
        if (arb_if.gnt !== 4'b0000 || arb_if.busy !== 1'b0 || arb_if.gnt_idx !== 2'd3 || arb_if.timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold gnt=%b busy=%b idx=%0d to=%b want 0000 0 3 0", arb_if.gnt, arb_if.busy, arb_if.gnt_idx, arb_if.timeout);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (arb_if.gnt !== 4'b0000 || arb_if.busy !== 1'b0 || arb_if.gnt_idx !== 2'd3 || arb_if.timeout !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle[%0d] gnt=%b busy=%b idx=%0d to=%b want 0000 0 3 0", i, arb_if.gnt, arb_if.busy, arb_if.gnt_idx, arb_if.timeout);
            end
        end
    endtask

    task automatic test_glitch();
        arb_if.req = 4'b0100;
        #3;
        arb_if.req = 4'b0000;
        tick();
        total++;
        if (arb_if.gnt !== 4'b0000 || arb_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL glitch gnt=%b busy=%b want 0000 0", arb_if.gnt, arb_if.busy);
        end
    endtask

    task automatic test_single();
        arb_if.req = 4'b0100;
        tick();
        total++;
        if (arb_if.gnt !== 4'b0100 || arb_if.gnt_idx !== 2'd2 || arb_if.busy !== 1'b1) begin
            bad++;
            $display("FAIL single_grant gnt=%b idx=%0d busy=%b want 0100 2 1", arb_if.gnt, arb_if.gnt_idx, arb_if.busy);
        end
        tick();
        tick();
        tick();
        total++;
        if (arb_if.gnt !== 4'b0100) begin
            bad++;
            $display("FAIL single_hold gnt=%b want 0100", arb_if.gnt);
        end
        arb_if.done = 1'b1;
        tick();
        arb_if.done = 1'b0;
        arb_if.req  = 4'b0000;
        total++;
        if (arb_if.gnt !== 4'b0000 || arb_if.busy !== 1'b0 || arb_if.gnt_idx !== 2'd2 || arb_if.timeout !== 1'b0) begin
            bad++;
            $display("FAIL single_turn gnt=%b busy=%b idx=%0d to=%b want 0000 0 2 0", arb_if.gnt, arb_if.busy, arb_if.gnt_idx, arb_if.timeout);
        end
        tick();
        total++;
        if (arb_if.gnt !== 4'b0000 || arb_if.gnt_idx !== 2'd2) begin
            bad++;
            $display("FAIL single_idle gnt=%b idx=%0d want 0000 2", arb_if.gnt, arb_if.gnt_idx);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_gnt [5];
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        arb_if.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 3; j++) begin
                tick();
                total++;
                if (arb_if.gnt !== exp_gnt[k]) begin
                    bad++;
                    $display("FAIL rotation[%0d.%0d] gnt=%b want %b", k, j, arb_if.gnt, exp_gnt[k]);
                end
                if (j == 2) arb_if.done = 1'b1;
            end
            tick();
            arb_if.done = 1'b0;
            total++;
            if (arb_if.gnt !== 4'b0000) begin
                bad++;
                $display("FAIL rotation_gap1[%0d] gnt=%b want 0000", k, arb_if.gnt);
            end
            tick();
            if (k == 4) arb_if.req = 4'b0000;
            total++;
            if (arb_if.gnt !== 4'b0000) begin
                bad++;
                $display("FAIL rotation_gap2[%0d] gnt=%b want 0000", k, arb_if.gnt);
            end
        end
    endtask

    task automatic test_skip();
        // Owner 0 from rotation; steer pointer to 1 first.
        arb_if.req = 4'b0010;
        tick();
        total++;
        if (arb_if.gnt !== 4'b0010 || arb_if.gnt_idx !== 2'd1) begin
            bad++;
            $display("FAIL skip_setup gnt=%b idx=%0d want 0010 1", arb_if.gnt, arb_if.gnt_idx);
        end
        arb_if.done = 1'b1;
        arb_if.req  = 4'b1001;
        tick();
        arb_if.done = 1'b0;
        total++;
        if (arb_if.gnt !== 4'b0000 || arb_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL skip_single_release gnt=%b busy=%b want 0000 0", arb_if.gnt, arb_if.busy);
        end
        tick();
        tick();
        total++;
        if (arb_if.gnt !== 4'b1000 || arb_if.gnt_idx !== 2'd3) begin
            bad++;
            $display("FAIL skip_to_3 gnt=%b idx=%0d want 1000 3", arb_if.gnt, arb_if.gnt_idx);
        end
        arb_if.done = 1'b1;
        tick();
        arb_if.done = 1'b0;
        tick();
        tick();
        total++;
        if (arb_if.gnt !== 4'b0001 || arb_if.gnt_idx !== 2'd0) begin
            bad++;
            $display("FAIL skip_to_0 gnt=%b idx=%0d want 0001 0", arb_if.gnt, arb_if.gnt_idx);
        end
        arb_if.done = 1'b1;
        tick();
        arb_if.done = 1'b0;
        tick();
        tick();
        total++;
        if (arb_if.gnt !== 4'b1000 || arb_if.gnt_idx !== 2'd3) begin
            bad++;
            $display("FAIL skip_back_to_3 gnt=%b idx=%0d want 1000 3", arb_if.gnt, arb_if.gnt_idx);
        end
        arb_if.req = 4'b0000;
        tick();
        total++;
        if (arb_if.gnt !== 4'b0000 || arb_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL skip_req_drop gnt=%b busy=%b want 0000 0", arb_if.gnt, arb_if.busy);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        arb_if.req = 4'b0010;
        tick();
        arb_if.req = 4'b1111;
        tick();
        total++;
        if (arb_if.gnt !== 4'b0010) begin
            bad++;
            $display("FAIL rstmid_setup gnt=%b want 0010", arb_if.gnt);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (arb_if.gnt !== 4'b0000 || arb_if.busy !== 1'b0 || arb_if.gnt_idx !== 2'd3) begin
            bad++;
            $display("FAIL rstmid_async gnt=%b busy=%b idx=%0d want 0000 0 3", arb_if.gnt, arb_if.busy, arb_if.gnt_idx);
        end
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (arb_if.gnt !== 4'b0001 || arb_if.gnt_idx !== 2'd0) begin
            bad++;
            $display("FAIL rstmid_first_grant gnt=%b idx=%0d want 0001 0", arb_if.gnt, arb_if.gnt_idx);
        end
        arb_if.req = 4'b0000;
        tick();
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] exp_regrant;
        // Pointer is 0; the forced owner goes to the back of the queue.
        for (int pass = 0; pass < 2; pass++) begin
            arb_if.req  = (pass == 0) ? 4'b0001 : 4'b0011;
            exp_regrant = (pass == 0) ? 4'b0001 : 4'b0010;
            for (int i = 0; i < 4; i++) begin
                tick();
                total++;
                if (arb_if.gnt !== 4'b0001 || arb_if.timeout !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_hold[%0d.%0d] gnt=%b to=%b want 0001 0", pass, i, arb_if.gnt, arb_if.timeout);
                end
            end
            tick();
            total++;
            if (arb_if.gnt !== 4'b0000 || arb_if.timeout !== 1'b1) begin
                bad++;
                $display("FAIL timeout_pulse[%0d] gnt=%b to=%b want 0000 1", pass, arb_if.gnt, arb_if.timeout);
            end
            tick();
            total++;
            if (arb_if.gnt !== 4'b0000 || arb_if.timeout !== 1'b0) begin
                bad++;
                $display("FAIL timeout_idle[%0d] gnt=%b to=%b want 0000 0", pass, arb_if.gnt, arb_if.timeout);
            end
            tick();
            total++;
            if (arb_if.gnt !== exp_regrant) begin
                bad++;
                $display("FAIL timeout_regrant[%0d] gnt=%b want %b", pass, arb_if.gnt, exp_regrant);
            end
            if (pass == 0) begin
                // Regrant of owner 0 is the first hold of pass 1; undo one tick of its count.
                arb_if.req = 4'b0011;
                for (int i = 1; i < 4; i++) begin
                    tick();
                    total++;
                    if (arb_if.gnt !== 4'b0001 || arb_if.timeout !== 1'b0) begin
                        bad++;
                        $display("FAIL timeout_hold2[%0d] gnt=%b to=%b want 0001 0", i, arb_if.gnt, arb_if.timeout);
                    end
                end
                tick();
                total++;
                if (arb_if.gnt !== 4'b0000 || arb_if.timeout !== 1'b1) begin
                    bad++;
                    $display("FAIL timeout_pulse2 gnt=%b to=%b want 0000 1", arb_if.gnt, arb_if.timeout);
                end
                tick();
                tick();
                total++;
                if (arb_if.gnt !== 4'b0010 || arb_if.gnt_idx !== 2'd1) begin
                    bad++;
                    $display("FAIL timeout_regrant_to_1 gnt=%b idx=%0d want 0010 1", arb_if.gnt, arb_if.gnt_idx);
                end
                break;
            end
        end
        arb_if.req = 4'b0000;
        tick();
        tick();
    endtask
`else
    task automatic test_timeout();
        arb_if.req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (arb_if.gnt !== 4'b0001 || arb_if.timeout !== 1'b0) begin
                bad++;
                $display("FAIL unbounded_hold[%0d] gnt=%b to=%b want 0001 0", i, arb_if.gnt, arb_if.timeout);
            end
        end
        arb_if.req = 4'b0000;
        tick();
        total++;
        if (arb_if.gnt !== 4'b0000 || arb_if.timeout !== 1'b0) begin
            bad++;
            $display("FAIL unbounded_release gnt=%b to=%b want 0000 0", arb_if.gnt, arb_if.timeout);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_glitch();
        test_single();
        test_rotation();
        test_skip();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_arb_4.md
Name: rr_arb_4

Overview:
- Four-requester round-robin arbiter for one shared resource.
- Owner is tracked as a 2-bit index. The one-hot grant vector is the 2-to-4 decode of that index, enabled by busy.
- Sits between four client blocks and the shared resource.
- Sequences ownership with a request/done handshake and a mandatory one-cycle turnaround between owners.

Parameters:
- MAX_HOLD, 16: maximum cycles one owner may hold the grant (used only with ARB_TIMEOUT_EN); legal range 1..2^CNT_W-1.
- CNT_W, 5: width of the hold counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  4  request per client; level, held high until served.
- done  input  1  owner's release pulse; sampled only in GRANT.
- gnt  output  4  one-hot grant = decode(gnt_idx) when busy, else 4'b0000.
- gnt_idx  output  2  index of current/last owner.
- busy  output  1  high while in GRANT.
- timeout  output  1  one-cycle pulse when a hold is force-released.

Behaviour:
- Reset values (asynchronous, while rst=1): state=IDLE, gnt=0000, gnt_idx=2'd3, busy=0, timeout=0, last pointer=3, hold counter=0.
  - Because the pointer resets to 3, client 0 has priority first.
- All outputs are registered; there is no combinational path from req or done to any output.
- FSM states: IDLE, GRANT, TURN.
- IDLE:
  - If req=0000, stay in IDLE.
  - Otherwise pick the winner by scanning from last+1 (mod 4) upward; the first set bit wins.
  - Next edge: state=GRANT, gnt_idx=winner, last=winner, busy=1, counter=0.
  - Latency from req sampled high to gnt high is 1 cycle.
- GRANT:
  - Release when done=1 or req[gnt_idx]=0 is sampled.
  - Next edge after release: state=TURN, busy=0, gnt=0000. gnt_idx keeps its value.
  - Otherwise the counter increments, saturating at 2^CNT_W-1.
- TURN:
  - Unconditional single dead cycle, then IDLE.
  - Minimum gap between owners is 2 cycles: TURN plus arbitration in IDLE.
- Simultaneous events:
  - done and a req change in the same cycle count as a single release.
  - req bits of non-owners are ignored in GRANT and TURN.
- Starvation freedom: with all four requesting continuously, grant order is 0,1,2,3,0,...
- Reset asserted mid-GRANT: gnt drops immediately (asynchronous); after deassert the arbiter restarts at IDLE with pointer 3.
- Glitching req in IDLE: only the value sampled at the edge matters.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when counter == MAX_HOLD-1 and no release is sampled, force release: next edge goes to TURN with timeout=1 for exactly that cycle.
  - last is still the forced owner, so that owner goes to the back of the queue.
  - If done or a req drop occurs in the same cycle as the limit, it is a normal release with timeout=0.
- Undefined:
  - No forced release; holds are unbounded.
  - timeout is tied to 0.
  - The counter logic is removed; the port list is unchanged.

Decomposition:
- Shared include file holds:
  - state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_TURN=2'd2;
  - the default MAX_HOLD;
  - ARB_NREQ=4.
- Sub-module rr_pick_4 (combinational):
  - inputs req[3:0] and last[1:0];
  - outputs valid and win[1:0];
  - rotate-and-priority-encode.
- gnt decode: decode(gnt_idx) gated by busy, in the top level.

Test Plan:
- Reset: rst=1, then 0; req=0000 for 5 cycles -> gnt=0000, busy=0, gnt_idx=3, timeout=0 throughout.
- Single requester: req=0100 at cycle 0 -> gnt=0100, gnt_idx=2 at cycle 1; done pulse at cycle 4 -> gnt=0000 at cycle 5 (TURN), IDLE at cycle 6.
- Rotation: req=1111 held, done pulsed every 3rd grant cycle -> grants observed in order 0001,0010,0100,1000,0001, each separated by exactly 2 cycles of gnt=0000.
- Skip logic: last=1, req=1001 -> next grant goes to 3 (gnt=1000), then to 0, then to 3 again.
- Reset mid-operation: rst=1 while gnt=0010 -> gnt=0000 in the same cycle without waiting for an edge; after release with req=1111 -> first grant goes to 0.
- With ARB_TIMEOUT_EN and MAX_HOLD=4: req=0001 held, no done -> gnt high for 4 cycles, then timeout=1 for one cycle with gnt=0000, then regrant to 0.
  - With req=0011 in the same setup, the regrant goes to 1.
